reu_register_file: RTL and testbench

- 1764/1750-compatible REU register file at $DF00-$DF1F, directly downstream of bus_manager's IOEF read/write strobes.
- Sits alongside system_registers ($DE page).
- Holds the transfer setup registers, handles execute, $FF00 trigger and autoload, and raises the REU interrupt.
- Upstream of the DMA transfer engine: issues start and parameters, tracks its step/done reports.

---
 rtl/reu_pkg.sv | 38 +++
 rtl/reu_addr_counter.sv | 56 +++++
 rtl/reu_register_file.sv | 202 ++++++++++++++++++++
 tb/tb_reu_register_file.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reu_pkg.sv
// REU register file shared definitions: register offsets, command types, FSM states, read masks.
// No logic; constants and types only.
// Imported by the register file and the address counter.
package reu_pkg;

    // Register offsets within the $DF00 page (a[4:0])
    localparam logic [4:0] REG_STATUS   = 5'h00;
    localparam logic [4:0] REG_COMMAND  = 5'h01;
    localparam logic [4:0] REG_C64_LO   = 5'h02;
    localparam logic [4:0] REG_C64_HI   = 5'h03;
    localparam logic [4:0] REG_REU_LO   = 5'h04;
    localparam logic [4:0] REG_REU_HI   = 5'h05;
    localparam logic [4:0] REG_REU_BANK = 5'h06;
    localparam logic [4:0] REG_LEN_LO   = 5'h07;
    localparam logic [4:0] REG_LEN_HI   = 5'h08;
    localparam logic [4:0] REG_IRQMASK  = 5'h09;
    localparam logic [4:0] REG_ADDRCTL  = 5'h0A;

    // Transfer type encodings carried on dma_type
    localparam logic [1:0] DMA_C64_TO_REU = 2'b00;
    localparam logic [1:0] DMA_REU_TO_C64 = 2'b01;
    localparam logic [1:0] DMA_SWAP       = 2'b10;
    localparam logic [1:0] DMA_VERIFY     = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } reu_state_e;

    // Bits that do not exist in hardware read back as 1
    localparam logic [7:0] CMD_WR_MASK     = 8'hB3;
    localparam logic [7:0] CMD_RD_ONES     = 8'h4C;
    localparam logic [7:0] MASK_RD_ONES    = 8'h1F;
    localparam logic [7:0] ADDRCTL_RD_ONES = 8'h3F;
    localparam logic [7:0] UNMAPPED_RD     = 8'hFF;

endpackage

// File: rtl/reu_addr_counter.sv
// Byte-writable address counter with reload shadow; writes land in both counter and shadow.
// Latency: one cycle from write/increment/reload to output.
// No backpressure; reload has priority over increment, increment over byte write.
module reu_addr_counter
    import reu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [1:0]   wr_sel_i,
    input  logic [7:0]   wr_dat_i,
    input  logic         inc_en_i,
    input  logic         fix_i,
    input  logic         reload_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] shadow_q, shadow_d;

    // Next-state: byte write into counter and shadow, then step, then reload override
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (wr_en_i) begin
            for (int i = 0; i < W; i++) begin
                if ((i / 8) == int'(wr_sel_i)) begin
                    cnt_d[i]    = wr_dat_i[3'(i % 8)];
                    shadow_d[i] = wr_dat_i[3'(i % 8)];
                end
            end
        end
        if (inc_en_i && !fix_i) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
        if (reload_i) begin
            cnt_d = shadow_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reu_register_file.sv
// REU register file at $DF00-$DF1F: setup registers, execute/$FF00 trigger, autoload, interrupt.
// Latency: read data valid the cycle after read_strobe; dma_start one cycle after the trigger.
// No backpressure; register writes are dropped while a transfer is running.
module reu_register_file
    import reu_pkg::*;
#(
    parameter int reu_bank_bits = 3,
    parameter bit size_bit      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [8:0]                  a,
    input  logic [7:0]                  d_d,
    output logic [7:0]                  d_q,
    input  logic                        read_strobe,
    input  logic                        write_strobe,
    input  logic                        ff00_write,
    output logic                        irq,
    output logic                        dma_start,
    output logic [1:0]                  dma_type,
    output logic [15:0]                 dma_c64_addr,
    output logic [16+reu_bank_bits-1:0] dma_reu_addr,
    output logic [15:0]                 dma_length,
    output logic                        dma_fix_c64,
    output logic                        dma_fix_reu,
    input  logic                        dma_step,
    input  logic                        dma_done,
    input  logic                        dma_verify_error
);

    localparam int RW = 16 + reu_bank_bits;

    reu_state_e  state_q;
    logic        start_q;
    logic [7:0]  cmd_q, cmd_d;
    logic        eob_q, eob_d, fault_q, fault_d;
    logic [2:0]  mask_q, mask_d;
    logic [1:0]  addrctl_q, addrctl_d;
    logic [15:0] len_q, len_d, len_sh_q, len_sh_d;
    logic [7:0]  rd_q, rd_dat, bank_rd;
    logic [4:0]  off;
    logic        reg_wr, reg_rd, cmd_wr, step_en, done_ev, reload, irq_bit;
    logic        c64_wr, reu_wr;
    logic        unused_addr_bits;

    assign off              = a[4:0];
    assign unused_addr_bits = ^a[7:5];
    assign reg_wr  = write_strobe & a[8] & (state_q != RUN);
    assign reg_rd  = read_strobe & a[8];
    assign cmd_wr  = reg_wr & (off == REG_COMMAND);
    assign step_en = dma_step & (state_q == RUN);
    assign done_ev = dma_done & (state_q == RUN);
    assign reload  = done_ev & cmd_q[5];
    assign c64_wr  = reg_wr & ((off == REG_C64_LO) | (off == REG_C64_HI));
    assign reu_wr  = reg_wr & ((off == REG_REU_LO) | (off == REG_REU_HI) | (off == REG_REU_BANK));
    assign irq_bit = mask_q[2] & ((mask_q[1] & eob_q) | (mask_q[0] & fault_q));

    reu_addr_counter #(.W(16)) u_c64_cnt (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (c64_wr),
        .wr_sel_i ({1'b0, off == REG_C64_HI}),
        .wr_dat_i (d_d),
        .inc_en_i (step_en),
        .fix_i    (addrctl_q[1]),
        .reload_i (reload),
        .cnt_o    (dma_c64_addr)
    );

    reu_addr_counter #(.W(RW)) u_reu_cnt (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (reu_wr),
        .wr_sel_i (2'(off - REG_REU_LO)),
        .wr_dat_i (d_d),
        .inc_en_i (step_en),
        .fix_i    (addrctl_q[0]),
        .reload_i (reload),
        .cnt_o    (dma_reu_addr)
    );

    // Read mux; missing bits read as 1, unmapped offsets read $FF
    always_comb begin
        bank_rd = 8'hFF;
        bank_rd[reu_bank_bits-1:0] = dma_reu_addr[RW-1:16];
        case (off)
            REG_STATUS:   rd_dat = {irq_bit, eob_q, fault_q, size_bit, 4'h0};
            REG_COMMAND:  rd_dat = cmd_q | CMD_RD_ONES;
            REG_C64_LO:   rd_dat = dma_c64_addr[7:0];
            REG_C64_HI:   rd_dat = dma_c64_addr[15:8];
            REG_REU_LO:   rd_dat = dma_reu_addr[7:0];
            REG_REU_HI:   rd_dat = dma_reu_addr[15:8];
            REG_REU_BANK: rd_dat = bank_rd;
            REG_LEN_LO:   rd_dat = len_q[7:0];
            REG_LEN_HI:   rd_dat = len_q[15:8];
            REG_IRQMASK:  rd_dat = {mask_q, 5'h00} | MASK_RD_ONES;
            REG_ADDRCTL:  rd_dat = {addrctl_q, 6'h00} | ADDRCTL_RD_ONES;
            default:      rd_dat = UNMAPPED_RD;
        endcase
    end

    // Register next-state: writes, read-clear of status, step, then transfer-end events win
    always_comb begin
        cmd_d     = cmd_q;
        mask_d    = mask_q;
        addrctl_d = addrctl_q;
        eob_d     = eob_q;
        fault_d   = fault_q;
        len_d     = len_q;
        len_sh_d  = len_sh_q;
        if (reg_wr) begin
            case (off)
                REG_COMMAND: cmd_d = d_d & CMD_WR_MASK;
                REG_LEN_LO:  begin len_d[7:0]  = d_d; len_sh_d[7:0]  = d_d; end
                REG_LEN_HI:  begin len_d[15:8] = d_d; len_sh_d[15:8] = d_d; end
                REG_IRQMASK: mask_d    = d_d[7:5];
                REG_ADDRCTL: addrctl_d = d_d[7:6];
                default:     ;
            endcase
        end
        if (reg_rd && off == REG_STATUS) begin
            eob_d   = 1'b0;
            fault_d = 1'b0;
        end
        // Length parks at 1 so the engine always sees a final byte pending
        if (step_en && len_q != 16'd1) begin
            len_d = len_q - 16'd1;
        end
        if (done_ev) begin
            cmd_d[7] = 1'b0;
            eob_d    = 1'b1;
            if (dma_verify_error) fault_d = 1'b1;
            if (reload) len_d = len_sh_q;
        end
    end

    // Register file state and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q     <= 8'h00;
            mask_q    <= 3'b000;
            addrctl_q <= 2'b00;
            eob_q     <= 1'b0;
            fault_q   <= 1'b0;
            len_q     <= 16'hFFFF;
            len_sh_q  <= 16'hFFFF;
            rd_q      <= 8'hFF;
        end else begin
            cmd_q     <= cmd_d;
            mask_q    <= mask_d;
            addrctl_q <= addrctl_d;
            eob_q     <= eob_d;
            fault_q   <= fault_d;
            len_q     <= len_d;
            len_sh_q  <= len_sh_d;
            if (reg_rd) rd_q <= rd_dat;
        end
    end

    // Transfer control FSM; dma_start is a registered one-cycle pulse on entry to RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_wr && d_d[7]) begin
                        if (d_d[4]) begin
                            state_q <= RUN;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (cmd_wr && !d_d[7]) begin
                        state_q <= IDLE;
                    end else if (ff00_write) begin
                        state_q <= RUN;
                        start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (dma_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign d_q         = rd_q;
    assign irq         = irq_bit;
    assign dma_start   = start_q;
    assign dma_type    = cmd_q[1:0];
    assign dma_length  = len_q;
    assign dma_fix_c64 = addrctl_q[1];
    assign dma_fix_reu = addrctl_q[0];

endmodule

// File: tb/tb_reu_register_file.sv
// Bench for reu_register_file: register read/write vector table, scoreboard on d_q,
// hand-written sequences for execute, $FF00 trigger, autoload, fixed addresses and wrap.
module tb_reu_register_file;

    localparam int BB = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [8:0]      a;
    logic [7:0]      d_d, d_q;
    logic            read_strobe, write_strobe, ff00_write;
    logic            irq, dma_start;
    logic [1:0]      dma_type;
    logic [15:0]     dma_c64_addr, dma_length;
    logic [16+BB-1:0] dma_reu_addr;
    logic            dma_fix_c64, dma_fix_reu;
    logic            dma_step, dma_done, dma_verify_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reu_register_file #(.reu_bank_bits(BB), .size_bit(1'b1)) dut (
        .clk              (clk),
        .reset            (reset),
        .a                (a),
        .d_d              (d_d),
        .d_q              (d_q),
        .read_strobe      (read_strobe),
        .write_strobe     (write_strobe),
        .ff00_write       (ff00_write),
        .irq              (irq),
        .dma_start        (dma_start),
        .dma_type         (dma_type),
        .dma_c64_addr     (dma_c64_addr),
        .dma_reu_addr     (dma_reu_addr),
        .dma_length       (dma_length),
        .dma_fix_c64      (dma_fix_c64),
        .dma_fix_reu      (dma_fix_reu),
        .dma_step         (dma_step),
        .dma_done         (dma_done),
        .dma_verify_error (dma_verify_error)
    );

    typedef struct {
        bit         wr;
        logic [4:0] off;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0] off;
        logic [7:0] exp;
        int         tag;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    sb_t  sb_e;
    logic rd_seen = 1'b0;

    // A read strobe sampled at this edge means d_q is due for comparison before the next edge
    always @(posedge clk) rd_seen <= read_strobe & a[8];

    always @(negedge clk) begin
        if (rd_seen) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: d_q=%h with nothing expected", d_q);
            end else begin
                sb_e = sb_q.pop_front();
                if (d_q !== sb_e.exp) begin
                    n_fail++;
                    $display("FAIL rd#%0d off %h: d_q=%h expected %h", sb_e.tag, sb_e.off, d_q, sb_e.exp);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] off, input logic [7:0] dat);
        @(posedge clk); #1;
        a = {4'b1000, off}; d_d = dat; write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [4:0] off, input logic [7:0] exp, input int tag);
        @(posedge clk); #1;
        a = {4'b1000, off}; read_strobe = 1'b1;
        sb_q.push_back('{off, exp, tag});
        @(posedge clk); #1;
        read_strobe = 1'b0;
    endtask

    task automatic steps(input int n);
        @(posedge clk); #1;
        dma_step = 1'b1;
        repeat (n) @(posedge clk);
        #1 dma_step = 1'b0;
    endtask

    task automatic done(input logic verr);
        @(posedge clk); #1;
        dma_done = 1'b1; dma_verify_error = verr;
        @(posedge clk); #1;
        dma_done = 1'b0; dma_verify_error = 1'b0;
    endtask

    task automatic ff00();
        @(posedge clk); #1;
        ff00_write = 1'b1;
        @(posedge clk); #1;
        ff00_write = 1'b0;
    endtask

    task automatic add(input bit w, input logic [4:0] off, input logic [7:0] dat, input logic [7:0] exp);
        vecs.push_back('{w, off, dat, exp});
    endtask

    initial begin
        // Reset-state reads, then setup writes and read-back
        add(0, 5'h00, 8'h00, 8'h10);
        add(0, 5'h07, 8'h00, 8'hFF);
        add(0, 5'h08, 8'h00, 8'hFF);
        add(0, 5'h0B, 8'h00, 8'hFF);
        add(0, 5'h01, 8'h00, 8'h4C);
        add(0, 5'h09, 8'h00, 8'h1F);
        add(0, 5'h0A, 8'h00, 8'h3F);
        add(0, 5'h06, 8'h00, 8'hF8);
        add(0, 5'h02, 8'h00, 8'h00);
        add(1, 5'h02, 8'h00, 8'h00);
        add(1, 5'h03, 8'hC0, 8'h00);
        add(1, 5'h04, 8'h00, 8'h00);
        add(1, 5'h05, 8'h10, 8'h00);
        add(1, 5'h06, 8'h02, 8'h00);
        add(1, 5'h07, 8'h03, 8'h00);
        add(1, 5'h08, 8'h00, 8'h00);
        add(1, 5'h0B, 8'h55, 8'h00);
        add(0, 5'h03, 8'h00, 8'hC0);
        add(0, 5'h05, 8'h00, 8'h10);
        add(0, 5'h06, 8'h00, 8'hFA);
        add(0, 5'h07, 8'h00, 8'h03);
        add(0, 5'h0B, 8'h00, 8'hFF);

        a = '0; d_d = '0; read_strobe = 0; write_strobe = 0; ff00_write = 0;
        dma_step = 0; dma_done = 0; dma_verify_error = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_d_q", 32'(d_q), 32'h FF);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_start", 32'(dma_start), 32'h0);
        check("reset_len", 32'(dma_length), 32'hFFFF);

        foreach (vecs[i]) begin
            if (vecs[i].wr) wr(vecs[i].off, vecs[i].dat);
            else            rd(vecs[i].off, vecs[i].exp, i);
        end

        // Direct execute with FF00 disabled
        wr(5'h01, 8'h90);
        check("exec_start", 32'(dma_start), 32'h1);
        check("exec_type", 32'(dma_type), 32'h0);
        check("exec_c64", 32'(dma_c64_addr), 32'hC000);
        check("exec_reu", 32'(dma_reu_addr), 32'h021000);
        check("exec_len", 32'(dma_length), 32'h3);
        @(posedge clk); #1;
        check("exec_start_pulse", 32'(dma_start), 32'h0);
        steps(3);
        done(1'b0);
        check("run1_c64", 32'(dma_c64_addr), 32'hC003);
        check("run1_reu", 32'(dma_reu_addr), 32'h021003);
        check("run1_len_parks", 32'(dma_length), 32'h1);
        rd(5'h00, 8'h50, 100);
        rd(5'h00, 8'h10, 101);
        rd(5'h01, 8'h5C, 102);

        // FF00-triggered transfer with autoload, verify error and irq
        wr(5'h09, 8'hE0);
        wr(5'h01, 8'hA1);
        repeat (3) begin
            @(posedge clk); #1;
            check("armed_no_start", 32'(dma_start), 32'h0);
        end
        ff00();
        check("ff00_start", 32'(dma_start), 32'h1);
        check("ff00_type", 32'(dma_type), 32'h1);
        steps(2);
        check("run2_c64", 32'(dma_c64_addr), 32'hC005);
        done(1'b1);
        check("run2_irq", 32'(irq), 32'h1);
        check("run2_reload_c64", 32'(dma_c64_addr), 32'hC000);
        check("run2_reload_reu", 32'(dma_reu_addr), 32'h021000);
        check("run2_reload_len", 32'(dma_length), 32'h3);
        rd(5'h00, 8'hF0, 103);
        check("run2_irq_cleared", 32'(irq), 32'h0);
        rd(5'h01, 8'h6D, 104);

        // Both addresses fixed; a write during RUN is ignored
        wr(5'h0A, 8'hC0);
        wr(5'h07, 8'h10);
        wr(5'h01, 8'h90);
        check("fix_start", 32'(dma_start), 32'h1);
        check("fix_flags", 32'({dma_fix_c64, dma_fix_reu}), 32'h3);
        wr(5'h02, 8'h55);
        steps(4);
        check("fix_c64", 32'(dma_c64_addr), 32'hC000);
        check("fix_reu", 32'(dma_reu_addr), 32'h021000);
        check("fix_len", 32'(dma_length), 32'h000C);
        done(1'b0);
        check("fix_irq_eob", 32'(irq), 32'h1);
        rd(5'h02, 8'h00, 105);
        rd(5'h0A, 8'hFF, 106);
        rd(5'h00, 8'hD0, 107);

        // Arm then cancel: a later $FF00 write must not start a transfer
        wr(5'h01, 8'hA0);
        wr(5'h01, 8'h00);
        ff00();
        check("cancel_no_start", 32'(dma_start), 32'h0);
        rd(5'h01, 8'h4C, 108);

        // REU address wraps within 16+BB bits
        wr(5'h0A, 8'h00);
        wr(5'h04, 8'hFF);
        wr(5'h05, 8'hFF);
        wr(5'h06, 8'h07);
        rd(5'h06, 8'hFF, 109);
        wr(5'h01, 8'h90);
        check("wrap_before", 32'(dma_reu_addr), 32'h07FFFF);
        steps(1);
        check("wrap_reu", 32'(dma_reu_addr), 32'h000000);
        check("wrap_c64", 32'(dma_c64_addr), 32'hC001);
        check("wrap_len", 32'(dma_length), 32'h000B);
        done(1'b0);

        repeat (2) @(posedge clk);
        #1 check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
